br_commit_arb: RTL and testbench
================================

BR_COMMIT_ARB -- requirements
Module: br_commit_arb

Interface
REQ-001 Parameter DEPTH, default 8: queue entries; power of two, at least 4.
REQ-002 Parameter PTR_WIDTH, default 3: log2(DEPTH).
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cm_valid  in  2  per-slot valid for committed branches (slot 0 is older).
REQ-006 cm_is_taken  in  2  per-slot resolved direction.
REQ-007 cm_pc  in  2x32  per-slot branch PC.
REQ-008 cm_type  in  2x rv_br_type  per-slot branch type.
REQ-009 cm_npc  in  2x32  per-slot resolved target.
REQ-010 cm_ready  out  1  commit stage may present records this cycle.
REQ-011 br_valid  out  1  head record is presented to the predictor update port.
REQ-012 br_is_taken, br_pc, br_pc_type, br_npc  out  1/32/rv_br_type/32  fields of the head record.
REQ-013 br_ready  in  1  predictor accepts the head record.
REQ-014 drain_req  in  1  request to empty the queue, e.g. before a predictor snapshot.
REQ-015 drain_done  out  1  one-cycle pulse: queue is empty and the drain has completed.
REQ-016 count  out  PTR_WIDTH+1  current occupancy.

Function
REQ-017 Records are stored in a circular FIFO of DEPTH entries; each entry holds is_taken, pc, type and npc.
REQ-018 A slot is enqueued when cm_valid[i] and cm_ready are both 1 in the same cycle.
REQ-019 Slot 0 is written before slot 1; if only slot 1 is valid, it takes a single entry at the tail.
REQ-020 cm_ready = (DEPTH - count >= 2) and state == RUN; it is combinational from registered state only, never from cm_valid.
REQ-021 br_valid = (count != 0), with zero-cycle latency. The br_* fields come from the head entry and stay stable while br_valid=1 and br_ready=0.
REQ-022 A dequeue occurs when br_valid and br_ready are both 1; at most one record is dequeued per cycle.
REQ-023 Next count = count + enqueued - dequeued.
REQ-024 Simultaneous enqueue and dequeue in the same cycle is legal, including at count=DEPTH-2 with two enqueues and one dequeue.
REQ-025 Read and write pointers wrap modulo DEPTH; order is strictly FIFO across the wrap.
REQ-026 A record enqueued in cycle N is visible at the head no earlier than cycle N+1 (no bypass).
REQ-027 FSM states are RUN and DRAIN.
REQ-028 RUN to DRAIN when drain_req=1.
REQ-029 In DRAIN, cm_ready=0 and dequeue continues.
REQ-030 In DRAIN with count==0, drain_done=1 for exactly that cycle and next state is RUN.
REQ-031 drain_req in RUN with an empty queue: DRAIN in the next cycle, with drain_done in that same cycle.
REQ-032 drain_req is ignored while in DRAIN.
REQ-033 Overflow and underflow are impossible by construction; cm_valid while cm_ready=0 has no effect.

Reset
REQ-034 While reset=0: count=0, pointers=0, state=RUN, br_valid=0, drain_done=0, cm_ready=1.
REQ-035 Entry payloads are not reset.
REQ-036 Reset asserted mid-operation discards all queued records immediately and asynchronously; no partial drain_done is produced.

Structure
REQ-037 rv_br_type and its BR_TYPE_* encodings come from the shared struct package; no local redefinition.
REQ-038 Storage is a single sub-module br_commit_fifo (2-write/1-read circular buffer with pointers and count); the FSM and handshake logic stay in br_commit_arb.

Verification
REQ-039 After reset release, cm_valid=2'b11 with pcs 0x100/0x104 and br_ready=1: br_pc=0x100 in cycle 1 and 0x104 in cycle 2; count goes 2, 1, 0.
REQ-040 br_ready=0 with 3 cycles of dual enqueue: count=6 and cm_ready=1; after a 4th dual enqueue, count=8 and cm_ready=0; br_* stays at the first record.
REQ-041 At count=6, dual enqueue with br_ready=1: count=7, and cm_ready=0 the next cycle.
REQ-042 Fill and drain 20 records with random br_ready: the output sequence equals the input order across the pointer wrap, with no loss or duplication.
REQ-043 drain_req with 3 queued records and br_ready=1: cm_ready=0 for 3 cycles, drain_done pulses once when count=0, then RUN resumes with cm_ready=1.
REQ-044 reset=0 asserted asynchronously with 5 queued records: count=0 and br_valid=0 immediately, with no drain_done.

Source files
------------

// File: rtl/br_commit_arb_pkg.sv
// Shared types for the branch commit arbiter: branch-type encoding, queue record, FSM states.
package br_commit_arb_pkg;

  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic [2:0] {
    BR_TYPE_NONE   = 3'd0,
    BR_TYPE_BRANCH = 3'd1,
    BR_TYPE_JAL    = 3'd2,
    BR_TYPE_JALR   = 3'd3,
    BR_TYPE_CALL   = 3'd4,
    BR_TYPE_RET    = 3'd5
  } rv_br_type;

  typedef struct packed {
    logic                is_taken;
    logic [PC_WIDTH-1:0] pc;
    rv_br_type           br_type;
    logic [PC_WIDTH-1:0] npc;
  } br_rec_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/br_commit_fifo.sv
// Two-write / one-read circular buffer of committed branch records.
module br_commit_fifo
  import br_commit_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           wr_en,
  input  br_rec_t [1:0]        wr_data,
  input  logic                 rd_en,
  output br_rec_t              rd_data,
  output logic [PTR_WIDTH:0]   count
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  br_rec_t              mem_q [DEPTH];
  br_rec_t              mem_d [DEPTH];

  // Slot 0 lands before slot 1; a lone valid slot takes a single entry at the tail.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_inc = wr_ptr_q + PTR_WIDTH'(1);
    wr_ptr_d   = wr_ptr_q;
    case (wr_en)
      2'b11: begin
        mem_d[wr_ptr_q]   = wr_data[0];
        mem_d[wr_ptr_inc] = wr_data[1];
        wr_ptr_d          = wr_ptr_q + PTR_WIDTH'(2);
      end
      2'b01: begin
        mem_d[wr_ptr_q] = wr_data[0];
        wr_ptr_d        = wr_ptr_inc;
      end
      2'b10: begin
        mem_d[wr_ptr_q] = wr_data[1];
        wr_ptr_d        = wr_ptr_inc;
      end
      default: ;
    endcase
  end

  // Read pointer and occupancy bookkeeping.
  always_comb begin
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en[0]) + CNT_W'(wr_en[1]) - CNT_W'(rd_en);
  end

  // Pointer and count state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/br_commit_arb.sv
// Commit-to-predictor record queue with RUN/DRAIN control and ready/valid handshakes.
module br_commit_arb
  import br_commit_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 cm_valid,
  input  logic [1:0]                 cm_is_taken,
  input  logic [1:0][PC_WIDTH-1:0]   cm_pc,
  input  rv_br_type [1:0]            cm_type,
  input  logic [1:0][PC_WIDTH-1:0]   cm_npc,
  output logic                       cm_ready,
  output logic                       br_valid,
  output logic                       br_is_taken,
  output logic [PC_WIDTH-1:0]        br_pc,
  output rv_br_type                  br_pc_type,
  output logic [PC_WIDTH-1:0]        br_npc,
  input  logic                       br_ready,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic [PTR_WIDTH:0]         count
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  arb_state_e    state_q, state_d;
  logic [1:0]    wr_en;
  br_rec_t [1:0] wr_data;
  br_rec_t       head;
  logic          rd_en;

  // Next state and handshake decode; depends only on registered state and count.
  always_comb begin
    state_d    = state_q;
    cm_ready   = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        cm_ready = (count <= CNT_W'(DEPTH - 2));
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count == '0) begin
          drain_done = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Pack per-slot commit fields into queue records.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_data[i].is_taken = cm_is_taken[i];
      wr_data[i].pc       = cm_pc[i];
      wr_data[i].br_type  = cm_type[i];
      wr_data[i].npc      = cm_npc[i];
    end
  end

  assign wr_en    = cm_valid & {2{cm_ready}};
  assign br_valid = (count != '0);
  assign rd_en    = br_valid & br_ready;

  br_commit_fifo #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count)
  );

  assign br_is_taken = head.is_taken;
  assign br_pc       = head.pc;
  assign br_pc_type  = head.br_type;
  assign br_npc      = head.npc;

endmodule

// File: tb/tb_br_commit_arb.sv
// Randomized self-checking bench for br_commit_arb against a queue-based reference model.
module tb_br_commit_arb;
  import br_commit_arb_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned PTR_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           cm_valid;
  logic [1:0]           cm_is_taken;
  logic [1:0][31:0]     cm_pc;
  rv_br_type [1:0]      cm_type;
  logic [1:0][31:0]     cm_npc;
  logic                 cm_ready;
  logic                 br_valid;
  logic                 br_is_taken;
  logic [31:0]          br_pc;
  rv_br_type            br_pc_type;
  logic [31:0]          br_npc;
  logic                 br_ready;
  logic                 drain_req;
  logic                 drain_done;
  logic [PTR_WIDTH:0]   count;

  br_commit_arb #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cm_valid(cm_valid), .cm_is_taken(cm_is_taken), .cm_pc(cm_pc),
    .cm_type(cm_type), .cm_npc(cm_npc), .cm_ready(cm_ready),
    .br_valid(br_valid), .br_is_taken(br_is_taken), .br_pc(br_pc),
    .br_pc_type(br_pc_type), .br_npc(br_npc), .br_ready(br_ready),
    .drain_req(drain_req), .drain_done(drain_done), .count(count)
  );

  always #5 clk = ~clk;

  int        n_vec  = 0;
  int        n_miss = 0;
  br_rec_t   q[$];
  bit        in_drain = 1'b0;
  int        done_pulses = 0;
  int        rdy_low_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic br_rec_t slot_rec(input int i);
    br_rec_t r;
    r.is_taken = cm_is_taken[i];
    r.pc       = cm_pc[i];
    r.br_type  = cm_type[i];
    r.npc      = cm_npc[i];
    return r;
  endfunction

  task automatic rand_slots(input logic [1:0] v);
    cm_valid = v;
    for (int i = 0; i < 2; i++) begin
      cm_is_taken[i] = 1'($urandom);
      cm_pc[i]       = $urandom;
      cm_type[i]     = rv_br_type'(3'($urandom_range(0, 5)));
      cm_npc[i]      = $urandom;
    end
  endtask

  // One cycle: check outputs at the falling edge against the model, then advance the model.
  task automatic step();
    int unsigned n;
    bit exp_rdy, exp_done;
    br_rec_t hd;
    @(negedge clk);
    n        = q.size();
    exp_rdy  = !in_drain && ((DEPTH - n) >= 2);
    exp_done = in_drain && (n == 0);
    chk("count", 32'(count), 32'(n));
    chk("cm_ready", 32'(cm_ready), 32'(exp_rdy));
    chk("br_valid", 32'(br_valid), 32'(n != 0));
    chk("drain_done", 32'(drain_done), 32'(exp_done));
    if (n != 0) begin
      hd = q[0];
      chk("br_pc", br_pc, hd.pc);
      chk("br_npc", br_npc, hd.npc);
      chk("br_is_taken", 32'(br_is_taken), 32'(hd.is_taken));
      chk("br_pc_type", 32'(br_pc_type), 32'(hd.br_type));
    end
    if (exp_done) done_pulses++;
    if (!exp_rdy) rdy_low_cycles++;
    if (n != 0 && br_ready) void'(q.pop_front());
    if (exp_rdy) begin
      if (cm_valid[0]) q.push_back(slot_rec(0));
      if (cm_valid[1]) q.push_back(slot_rec(1));
    end
    if (!in_drain && drain_req) in_drain = 1'b1;
    else if (in_drain && n == 0) in_drain = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cm_valid  = 2'b00;
    drain_req = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    br_ready  = 1'b0;
    drain_req = 1'b0;
    rand_slots(2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_br_valid", 32'(br_valid), 32'd0);
    chk("rst_drain_done", 32'(drain_done), 32'd0);
    chk("rst_cm_ready", 32'(cm_ready), 32'd1);
    rst_n = 1'b1;

    // Two records back to back, drained immediately.
    rand_slots(2'b11);
    cm_pc[0] = 32'h100;
    cm_pc[1] = 32'h104;
    br_ready = 1'b1;
    step();
    idle();
    chk("seq_cnt2", 32'(count), 32'd2);
    chk("seq_pc0", br_pc, 32'h100);
    step();
    chk("seq_cnt1", 32'(count), 32'd1);
    chk("seq_pc1", br_pc, 32'h104);
    step();
    chk("seq_cnt0", 32'(count), 32'd0);

    // Fill to full with the predictor stalled.
    br_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_slots(2'b11);
      if (k == 0) cm_pc[0] = 32'hCAFE_0000;
      step();
    end
    chk("full_cnt6", 32'(count), 32'd6);
    chk("full_rdy6", 32'(cm_ready), 32'd1);
    rand_slots(2'b11);
    step();
    idle();
    chk("full_cnt8", 32'(count), 32'd8);
    chk("full_rdy8", 32'(cm_ready), 32'd0);
    chk("full_head", br_pc, 32'hCAFE_0000);
    rand_slots(2'b11);
    step();
    chk("full_ignored", 32'(count), 32'd8);

    // Back to 6, then dual enqueue plus dequeue.
    idle();
    br_ready = 1'b1;
    step();
    step();
    chk("six_cnt", 32'(count), 32'd6);
    rand_slots(2'b11);
    step();
    idle();
    br_ready = 1'b0;
    chk("seven_cnt", 32'(count), 32'd7);
    chk("seven_rdy", 32'(cm_ready), 32'd0);

    // Empty out, then stream 20+ records across the pointer wrap with random backpressure.
    br_ready = 1'b1;
    for (int k = 0; k < 12 && q.size() != 0; k++) step();
    chk("empty_before_stream", 32'(q.size()), 32'd0);
    for (int k = 0; k < 40; k++) begin
      rand_slots(2'($urandom));
      br_ready = 1'($urandom);
      step();
    end
    idle();
    br_ready = 1'b1;
    for (int k = 0; k < 12 && q.size() != 0; k++) step();
    chk("stream_drained", 32'(count), 32'd0);

    // Drain with three queued records.
    rand_slots(2'b11);
    br_ready = 1'b0;
    step();
    rand_slots(2'b01);
    step();
    idle();
    chk("drain_pre_cnt", 32'(count), 32'd3);
    br_ready       = 1'b1;
    done_pulses    = 0;
    rdy_low_cycles = 0;
    drain_req      = 1'b1;
    step();
    drain_req = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("drain_pulses", 32'(done_pulses), 32'd1);
    chk("drain_rdy_low", 32'(rdy_low_cycles), 32'd3);
    chk("drain_resume", 32'(cm_ready), 32'd1);

    // Drain request on an empty queue.
    done_pulses = 0;
    drain_req   = 1'b1;
    step();
    drain_req = 1'b0;
    chk("empty_drain_done", 32'(drain_done), 32'd1);
    step();
    step();
    chk("empty_drain_pulses", 32'(done_pulses), 32'd1);

    // Random mix with occasional drain requests.
    for (int k = 0; k < 300; k++) begin
      rand_slots(2'($urandom));
      br_ready  = ($urandom_range(0, 3) != 0);
      drain_req = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();

    // Asynchronous reset with five queued records.
    br_ready = 1'b1;
    for (int k = 0; k < 12 && (q.size() != 0 || in_drain); k++) step();
    br_ready = 1'b0;
    rand_slots(2'b11);
    step();
    step();
    rand_slots(2'b01);
    step();
    idle();
    chk("arst_pre_cnt", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_br_valid", 32'(br_valid), 32'd0);
    chk("arst_drain_done", 32'(drain_done), 32'd0);
    q.delete();
    in_drain = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
